// File: rtl/ksa_shuffle_param_if.sv
// Controller/RAM-side bundle for the RC4 key-scheduling engine.
// The slave modport is the engine; the master side is the controller plus S-box RAM.
interface ksa_shuffle_param_if #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic                   init_en;
  logic [8*KEY_BYTES-1:0] key;
  logic [ADDR_W-1:0]      mem_rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ADDR_W-1:0]      mem_wdata;
  logic                   mem_we;
  logic                   busy;
  logic                   done;

  modport master (
    output start, init_en, key, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done
  );

  modport slave (
    input  start, init_en, key, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done
  );
endinterface

// File: rtl/ksa_shuffle_param.sv
// RC4 key-scheduling engine: optional identity fill of the S-box RAM, then the
// key-dependent swap loop, all through one single-port synchronous RAM.
module ksa_shuffle_param #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ksa_shuffle_param_if.slave bus
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WC_W   = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W-1:0] I_LAST  = '1;
  localparam logic [KIDX_W-1:0] K_LAST  = KIDX_W'(KEY_BYTES - 1);
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(RD_LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RD_I  = 3'd2;
  localparam logic [2:0] S_ADD_J = 3'd3;
  localparam logic [2:0] S_RD_J  = 3'd4;
  localparam logic [2:0] S_WR_I  = 3'd5;
  localparam logic [2:0] S_WR_J  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]             state;
  logic [ADDR_W-1:0]      i;
  logic [ADDR_W-1:0]      j;
  logic [KIDX_W-1:0]      kidx;
  logic [ADDR_W-1:0]      s_i;
  logic [ADDR_W-1:0]      s_j;
  logic [WC_W-1:0]        wcnt;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             kbyte;
  logic [ADDR_W-1:0]      kb;

  // Byte 0 sits in the most significant byte of the key word.
  always_comb begin
    kbyte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIDX_W'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign kb = ADDR_W'(kbyte);

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    case (state)
      S_FILL: begin
        bus.mem_addr  = i;
        bus.mem_wdata = i;
        bus.mem_we    = 1'b1;
      end
      S_RD_I: bus.mem_addr = i;
      S_RD_J: bus.mem_addr = j;
      S_WR_I: begin
        bus.mem_addr  = i;
        bus.mem_wdata = s_j;
        bus.mem_we    = 1'b1;
      end
      // When i == j this second write restores s_i, leaving the entry unchanged.
      S_WR_J: begin
        bus.mem_addr  = j;
        bus.mem_wdata = s_i;
        bus.mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state != S_IDLE) && (state != S_DONE);
  assign bus.done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      s_i   <= '0;
      s_j   <= '0;
      wcnt  <= '0;
      key_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            key_q <= bus.key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            wcnt  <= '0;
            state <= bus.init_en ? S_FILL : S_RD_I;
          end
        end
        S_FILL: begin
          i <= i + 1'b1;
          if (i == I_LAST) state <= S_RD_I;
        end
        // Address is held for RD_LAT+1 cycles; data is valid on the last edge.
        S_RD_I: begin
          if (wcnt == WC_LAST) begin
            s_i   <= bus.mem_rdata;
            wcnt  <= '0;
            state <= S_ADD_J;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_ADD_J: begin
          j     <= j + s_i + kb;
          state <= S_RD_J;
        end
        S_RD_J: begin
          if (wcnt == WC_LAST) begin
            s_j   <= bus.mem_rdata;
            wcnt  <= '0;
            state <= S_WR_I;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WR_I: state <= S_WR_J;
        S_WR_J: begin
          kidx <= (kidx == K_LAST) ? '0 : kidx + 1'b1;
          if (i == I_LAST) begin
            state <= S_DONE;
          end else begin
            i     <= i + 1'b1;
            state <= S_RD_I;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
